// File: rtl/rainbow_pkg.sv
// Colour wheel definitions shared by the hue sequencer and the blur driver.
// Colours are active-low RGB: bit2 = R, bit1 = B, bit0 = G.
package rainbow_pkg;

    localparam int N_BASE = 6;

    localparam logic [2:0] RED     = 3'b011;
    localparam logic [2:0] YELLOW  = 3'b010;
    localparam logic [2:0] GREEN   = 3'b110;
    localparam logic [2:0] CYAN    = 3'b100;
    localparam logic [2:0] BLUE    = 3'b101;
    localparam logic [2:0] MAGENTA = 3'b001;

    typedef enum logic {
        S_OFFER = 1'b0,
        S_WAIT  = 1'b1
    } seq_state_t;

    // Base colour for wheel position 0..5; out-of-range indices fall back to RED.
    function automatic logic [2:0] wheel_color(input logic [2:0] idx);
        case (idx)
            3'd0:    wheel_color = RED;
            3'd1:    wheel_color = YELLOW;
            3'd2:    wheel_color = GREEN;
            3'd3:    wheel_color = CYAN;
            3'd4:    wheel_color = BLUE;
            3'd5:    wheel_color = MAGENTA;
            default: wheel_color = RED;
        endcase
    endfunction

    // Next wheel position, wrapping after the last base colour.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        if (idx == 3'(N_BASE - 1)) next_idx = 3'd0;
        else                       next_idx = idx + 3'd1;
    endfunction

endpackage

// File: rtl/rainbow_hue_seq_step_timer.sv
// Step pacing counter: counts enabled cycles and flags the last one of a step.
module step_timer #(
    parameter int STEP_TICKS = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] LAST = TW'(STEP_TICKS - 1);

    logic [TW-1:0] cnt;

    // Count enabled cycles; restart from zero on clear or after the last tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + TW'(1);
        end
    end

    assign done = (cnt == LAST) && enable;

endmodule

// File: rtl/rainbow_hue_seq.sv
// Hue sequencer: walks the six-colour wheel and offers each blend step
// {past colour, future colour, past bias} to the blur driver over valid/ready.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_OFFER | step_valid high, outputs frozen until the driver takes them
//  S_WAIT  | step_valid low, timer runs while enable is high
module rainbow_hue_seq
    import rainbow_pkg::*;
#(
    parameter int TICKS_PER_US = 12,
    parameter int STEP_US      = 20000,
    parameter int STEP_TICKS   = TICKS_PER_US * STEP_US,
    parameter int N_STEPS      = 50,
    parameter int BW           = $clog2(N_STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          step_ready,
    output logic          step_valid,
    output logic [2:0]    p_color,
    output logic [2:0]    f_color,
    output logic [BW-1:0] p_bias,
    output logic [2:0]    base_idx,
    output logic          cycle_done
);

    localparam logic [BW-1:0] BIAS_MAX = BW'(N_STEPS);

    seq_state_t state;
    logic       accept;
    logic       tick_en;
    logic       tick_done;
    logic [2:0] idx_next;

    assign accept   = (state == S_OFFER) && step_valid && step_ready;
    assign tick_en  = (state == S_WAIT) && enable;
    assign idx_next = next_idx(base_idx);

    step_timer #(
        .STEP_TICKS (STEP_TICKS)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (tick_en),
        .done   (tick_done)
    );

    // Offer/wait sequencing with the bias/hue advance on the wait->offer edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_OFFER;
            step_valid <= 1'b1;
            base_idx   <= 3'd0;
            p_color    <= RED;
            f_color    <= YELLOW;
            p_bias     <= BIAS_MAX;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                S_OFFER: begin
                    if (accept) begin
                        state      <= S_WAIT;
                        step_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (tick_done) begin
                        state      <= S_OFFER;
                        step_valid <= 1'b1;
                        if (p_bias > BW'(1)) begin
                            p_bias <= p_bias - BW'(1);
                        end else begin
                            // Bias 0 would equal the next base at full bias, so move on instead.
                            p_bias     <= BIAS_MAX;
                            base_idx   <= idx_next;
                            p_color    <= wheel_color(idx_next);
                            f_color    <= wheel_color(next_idx(idx_next));
                            cycle_done <= (base_idx == 3'(N_BASE - 1));
                        end
                    end
                end
                default: begin
                    state      <= S_OFFER;
                    step_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rainbow_hue_seq.sv
// Self-checking bench for rainbow_hue_seq with STEP_TICKS=4, N_STEPS=3.
module tb_rainbow_hue_seq;

    localparam int ST    = 4;
    localparam int NS    = 3;
    localparam int BW    = 2;
    localparam int NROWS = 29;

    localparam logic [2:0] R = 3'b011;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b110;
    localparam logic [2:0] C = 3'b100;
    localparam logic [2:0] B = 3'b101;
    localparam logic [2:0] M = 3'b001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          step_ready = 1'b0;
    logic          step_valid;
    logic [2:0]    p_color;
    logic [2:0]    f_color;
    logic [BW-1:0] p_bias;
    logic [2:0]    base_idx;
    logic          cycle_done;

    always #5 clk = ~clk;

    rainbow_hue_seq #(
        .STEP_TICKS (ST),
        .N_STEPS    (NS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .step_ready (step_ready),
        .step_valid (step_valid),
        .p_color    (p_color),
        .f_color    (f_color),
        .p_bias     (p_bias),
        .base_idx   (base_idx),
        .cycle_done (cycle_done)
    );

    // One expected offer plus the stimulus applied while it is presented.
    typedef struct {
        logic [2:0]    pc;
        logic [2:0]    fc;
        logic [BW-1:0] bias;
        logic [2:0]    idx;
        logic          cd;
        int            hold;    // cycles of ready low before accepting
        int            gap;     // enable-low cycles inserted in the following wait
        logic          en_acc;  // enable level at the accepting edge
    } vec_t;

    vec_t rows [NROWS];
    vec_t sbq [$];
    vec_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cd_pulses = 0;
    int   wl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_row(input int i, input logic [2:0] pc, input logic [2:0] fc,
                           input logic [BW-1:0] bias, input logic [2:0] idx, input logic cd,
                           input int hold, input int gap, input logic en_acc);
        rows[i].pc     = pc;
        rows[i].fc     = fc;
        rows[i].bias   = bias;
        rows[i].idx    = idx;
        rows[i].cd     = cd;
        rows[i].hold   = hold;
        rows[i].gap    = gap;
        rows[i].en_acc = en_acc;
    endtask

    always @(negedge clk) begin
        if (rst_n && cycle_done === 1'b1) cd_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           i   pc fc bias idx cd hold gap en
        set_row( 0, R, Y, 2'd3, 3'd0, 1'b0, 3,  0, 1'b1);
        set_row( 1, R, Y, 2'd2, 3'd0, 1'b0, 0,  0, 1'b1);
        set_row( 2, R, Y, 2'd1, 3'd0, 1'b0, 0,  0, 1'b1);
        set_row( 3, Y, G, 2'd3, 3'd1, 1'b0, 0,  0, 1'b1);
        set_row( 4, Y, G, 2'd2, 3'd1, 1'b0, 0,  0, 1'b1);
        set_row( 5, Y, G, 2'd1, 3'd1, 1'b0, 0,  0, 1'b1);
        set_row( 6, G, C, 2'd3, 3'd2, 1'b0, 0,  0, 1'b1);
        set_row( 7, G, C, 2'd2, 3'd2, 1'b0, 0,  0, 1'b1);
        set_row( 8, G, C, 2'd1, 3'd2, 1'b0, 0,  0, 1'b1);
        set_row( 9, C, B, 2'd3, 3'd3, 1'b0, 0,  0, 1'b1);
        set_row(10, C, B, 2'd2, 3'd3, 1'b0, 0,  0, 1'b1);
        set_row(11, C, B, 2'd1, 3'd3, 1'b0, 0,  0, 1'b1);
        set_row(12, B, M, 2'd3, 3'd4, 1'b0, 0,  0, 1'b1);
        set_row(13, B, M, 2'd2, 3'd4, 1'b0, 0,  0, 1'b1);
        set_row(14, B, M, 2'd1, 3'd4, 1'b0, 0,  0, 1'b1);
        set_row(15, M, R, 2'd3, 3'd5, 1'b0, 0,  0, 1'b1);
        set_row(16, M, R, 2'd2, 3'd5, 1'b0, 0,  0, 1'b1);
        set_row(17, M, R, 2'd1, 3'd5, 1'b0, 0,  0, 1'b1);
        set_row(18, R, Y, 2'd3, 3'd0, 1'b1, 1,  0, 1'b1);
        set_row(19, R, Y, 2'd2, 3'd0, 1'b0, 10, 0, 1'b1);
        set_row(20, R, Y, 2'd1, 3'd0, 1'b0, 0,  7, 1'b1);
        set_row(21, Y, G, 2'd3, 3'd1, 1'b0, 0,  0, 1'b0);
        set_row(22, Y, G, 2'd2, 3'd1, 1'b0, 0,  0, 1'b1);
        set_row(23, Y, G, 2'd1, 3'd1, 1'b0, 0,  0, 1'b1);
        set_row(24, G, C, 2'd3, 3'd2, 1'b0, 0,  0, 1'b1);
        set_row(25, G, C, 2'd2, 3'd2, 1'b0, 0,  0, 1'b1);
        set_row(26, G, C, 2'd1, 3'd2, 1'b0, 0,  0, 1'b1);
        set_row(27, C, B, 2'd3, 3'd3, 1'b0, 0,  0, 1'b1);
        set_row(28, C, B, 2'd2, 3'd3, 1'b0, 2,  0, 1'b1);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state", {step_valid, p_color, f_color, p_bias, base_idx, cycle_done},
            {1'b1, R, Y, 2'd3, 3'd0, 1'b0});

        sbq.push_back(rows[0]);
        enable = 1'b1;

        for (int i = 0; i < NROWS; i++) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at row %0d", i);
            end else begin
                e = sbq.pop_front();
            end
            chk($sformatf("offer%0d_valid", i), step_valid, 1'b1);
            chk($sformatf("offer%0d_p_color", i), p_color, e.pc);
            chk($sformatf("offer%0d_f_color", i), f_color, e.fc);
            chk($sformatf("offer%0d_p_bias", i), p_bias, e.bias);
            chk($sformatf("offer%0d_base_idx", i), base_idx, e.idx);
            chk($sformatf("offer%0d_cycle_done", i), cycle_done, e.cd);

            for (int h = 0; h < e.hold; h++) begin
                @(negedge clk);
                chk($sformatf("offer%0d_hold%0d", i, h),
                    {step_valid, p_color, f_color, p_bias, base_idx, cycle_done},
                    {1'b1, e.pc, e.fc, e.bias, e.idx, 1'b0});
            end

            if (i == NROWS - 1) break;

            enable     = e.en_acc;
            step_ready = 1'b1;
            @(posedge clk);
            sbq.push_back(rows[i + 1]);

            wl = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    step_ready = 1'b0;
                    enable     = 1'b1;
                end
                if (step_valid === 1'b1) break;
                wl++;
                if (e.gap > 0 && c == 2)         enable = 1'b0;
                if (e.gap > 0 && c == 2 + e.gap) enable = 1'b1;
            end
            chk($sformatf("wait%0d_len", i), wl, ST + e.gap);
        end

        // Reset in the middle of an offer at base_idx=3, p_bias=2.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midoffer_reset", {step_valid, p_color, f_color, p_bias, base_idx, cycle_done},
            {1'b1, R, Y, 2'd3, 3'd0, 1'b0});
        @(negedge clk);
        chk("post_reset_hold", {step_valid, p_color, f_color, p_bias, base_idx, cycle_done},
            {1'b1, R, Y, 2'd3, 3'd0, 1'b0});

        chk("cycle_done_pulses", cd_pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
